// File: rtl/matmul4x4_4x2_stream_if.sv
// Operand/result stream bundle for matmul4x4_4x2_stream.
// Latency: none, this is wiring only.
// Backpressure: input and output are independent valid/ready pairs.
// Signals: in_valid/in_data/in_ready carry operand beats (A0..A15 then B0..B7),
//          out_valid/out_data/out_last/out_ready carry results S0..S7, busy flags COMPUTE/DRAIN.
// Modports: master drives operands and accepts results, slave is the compute block.
interface matmul4x4_4x2_stream_if #(
  parameter int DATA_W = 16
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              out_ready;
  logic              busy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, busy
  );
endinterface

// File: rtl/matmul4x4_4x2_stream.sv
// Serial signed Q8.8 4x4 x 4x2 matrix product using one shared multiply-accumulate unit.
// Latency: first result is valid 33 cycles after the cycle of the final (24th) input handshake.
// Backpressure: in_ready only in LOAD; results hold stable while out_ready is low, no overlap between matrices.
// Ports: clk, rst (synchronous, active-high), mm (slave modport of matmul4x4_4x2_stream_if):
//   in_valid/in_data/in_ready operand beats, out_valid/out_data/out_last/out_ready results, busy.
// Build option: define MATMUL_SAT_EN to clamp each result to the signed DATA_W range instead of wrapping.
module matmul4x4_4x2_stream #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int ACC_W  = 2*DATA_W+2
) (
  input  logic                  clk,
  input  logic                  rst,
  matmul4x4_4x2_stream_if.slave mm
);

  localparam logic [1:0] ST_LOAD    = 2'd0;
  localparam logic [1:0] ST_COMPUTE = 2'd1;
  localparam logic [1:0] ST_DRAIN   = 2'd2;

  logic [1:0] state;
  logic [4:0] ld_idx;   // operand beat 0..23
  logic [4:0] cyc;      // compute cycle 0..31 = {result k, term j}
  logic [2:0] dr_idx;   // result currently presented

  logic signed [DATA_W-1:0] opbuf [24];  // 0..15 = A, 16..23 = B
  logic        [DATA_W-1:0] res   [8];
  logic signed [ACC_W-1:0]  acc;

  logic              in_ready_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_last_q;
  logic              busy_q;

  assign mm.in_ready  = in_ready_q;
  assign mm.out_valid = out_valid_q;
  assign mm.out_data  = out_data_q;
  assign mm.out_last  = out_last_q;
  assign mm.busy      = busy_q;

  // Compute-cycle decode: k = cyc[4:2] (row r = cyc[4:3], column c = cyc[2]), term j = cyc[1:0].
  logic [1:0] row_r;
  logic       col_c;
  logic [1:0] term_j;
  logic [2:0] res_k;

  assign row_r  = cyc[4:3];
  assign col_c  = cyc[2];
  assign term_j = cyc[1:0];
  assign res_k  = cyc[4:2];

  // A[4r+j] and B[2j+c]; B lives at offset 16 in the buffer.
  logic signed [DATA_W-1:0]   a_op;
  logic signed [DATA_W-1:0]   b_op;
  logic signed [2*DATA_W-1:0] a_ext;
  logic signed [2*DATA_W-1:0] b_ext;
  logic signed [2*DATA_W-1:0] prod;

  assign a_op  = opbuf[{1'b0, row_r, term_j}];
  assign b_op  = opbuf[{2'b10, term_j, col_c}];
  // Extending both operands first keeps the full signed product in the low 2*DATA_W bits.
  assign a_ext = {{DATA_W{a_op[DATA_W-1]}}, a_op};
  assign b_ext = {{DATA_W{b_op[DATA_W-1]}}, b_op};
  assign prod  = a_ext * b_ext;

  logic signed [ACC_W-1:0] acc_base;
  logic signed [ACC_W-1:0] acc_next;

  // Term 0 restarts the sum, so no separate clear cycle is needed between results.
  assign acc_base = (term_j == 2'd0) ? '0 : acc;
  assign acc_next = acc_base + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};

  // Arithmetic shift truncates toward minus infinity; no rounding bit is added.
  logic [DATA_W-1:0] res_val;

`ifdef MATMUL_SAT_EN
  logic signed [ACC_W-1:0] acc_shr;
  logic [ACC_W-DATA_W:0]   acc_hi;
  logic                    fits;

  assign acc_shr = acc_next >>> FRAC_W;
  // The value fits in DATA_W bits when every bit from the DATA_W sign position upward agrees.
  assign acc_hi  = acc_shr[ACC_W-1:DATA_W-1];
  assign fits    = (&acc_hi) | ~(|acc_hi);

  always_comb begin
    res_val = acc_shr[DATA_W-1:0];
    if (!fits) begin
      res_val = acc_shr[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                 : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end
`else
  assign res_val = DATA_W'(acc_next >>> FRAC_W);
`endif

  // Control path and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_LOAD;
      ld_idx      <= '0;
      cyc         <= '0;
      dr_idx      <= '0;
      acc         <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          in_ready_q <= 1'b1;
          if (mm.in_valid && in_ready_q) begin
            if (ld_idx == 5'd23) begin
              state      <= ST_COMPUTE;
              ld_idx     <= '0;
              cyc        <= '0;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b1;
            end else begin
              ld_idx <= ld_idx + 5'd1;
            end
          end
        end

        ST_COMPUTE: begin
          acc <= acc_next;
          cyc <= cyc + 5'd1;
          if (cyc == 5'd31) begin
            // S0 was written back at cycle 3, so it can be presented right away.
            state       <= ST_DRAIN;
            dr_idx      <= '0;
            out_valid_q <= 1'b1;
            out_data_q  <= res[0];
            out_last_q  <= 1'b0;
          end
        end

        ST_DRAIN: begin
          if (mm.out_ready) begin
            if (dr_idx == 3'd7) begin
              state       <= ST_LOAD;
              dr_idx      <= '0;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              in_ready_q  <= 1'b1;
              busy_q      <= 1'b0;
            end else begin
              dr_idx     <= dr_idx + 3'd1;
              out_data_q <= res[dr_idx + 3'd1];
              out_last_q <= (dr_idx == 3'd6);
            end
          end
        end

        default: begin
          state <= ST_LOAD;
        end
      endcase
    end
  end

  // Operand buffer: contents are meaningless until a full load completes, so no reset.
  always_ff @(posedge clk) begin
    if (!rst && state == ST_LOAD && mm.in_valid && in_ready_q) begin
      opbuf[ld_idx] <= mm.in_data;
    end
  end

  // Result buffer: written on the last term of each dot product.
  always_ff @(posedge clk) begin
    if (!rst && state == ST_COMPUTE && term_j == 2'd3) begin
      res[res_k] <= res_val;
    end
  end

endmodule

// File: tb/tb_matmul4x4_4x2_stream.sv
`timescale 1ns/1ps
module tb_matmul4x4_4x2_stream;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  matmul4x4_4x2_stream_if #(.DATA_W(16)) bus ();

  matmul4x4_4x2_stream #(.DATA_W(16), .FRAC_W(8), .ACC_W(34)) dut (
    .clk (clk),
    .rst (rst),
    .mm  (bus)
  );

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Operand tables (Q8.8): 0080=0.5 0180=1.5 fe80=-1.5 fc80=-3.5 0100=1 ff00=-1 fe00=-2 0300=3
  logic [15:0] a1 [16] = '{16'h0080, 16'h0180, 16'hfe80, 16'hfe80,
                           16'h0080, 16'hfc80, 16'hfe80, 16'hfe80,
                           16'hfe80, 16'h0180, 16'hfc80, 16'h0180,
                           16'hfc80, 16'hfc80, 16'h0080, 16'hfc80};
  logic [15:0] b1 [8] = '{16'hfc80, 16'hfc80, 16'hfc80, 16'hfc80,
                          16'h0080, 16'hfc80, 16'hfc80, 16'hfc80};
  logic [15:0] b2 [8] = '{16'hff00, 16'hff00, 16'h0100, 16'hfe00,
                          16'h0100, 16'hff00, 16'h0100, 16'hff00};
  logic [15:0] b3 [8] = '{16'hff00, 16'hff00, 16'h0100, 16'hfe00,
                          16'h0100, 16'hff00, 16'h0300, 16'hff00};

  // Hand-computed results (row r dot column c, then times 256):
  // A*b1: -2.5 3.5 15 21 -7 7 37 35
  logic [15:0] exp1 [8] = '{16'hfd80, 16'h0380, 16'h0f00, 16'h1500,
                            16'hf900, 16'h0700, 16'h2500, 16'h2300};
  // A*b2: -2 -0.5 -7 9.5 1 0.5 -3 13.5
  logic [15:0] exp2 [8] = '{16'hfe00, 16'hff80, 16'hf900, 16'h0980,
                            16'h0100, 16'h0080, 16'hfd00, 16'h0d80};
  // A*b3: column 0 gains 2*A[r][3]: -5 -0.5 -10 9.5 4 0.5 -10 13.5
  logic [15:0] exp3 [8] = '{16'hfb00, 16'hff80, 16'hf600, 16'h0980,
                            16'h0400, 16'h0080, 16'hf600, 16'h0d80};

  logic [15:0] ops [48];
  int          in_cyc [48];
  logic [15:0] got [8];
  logic        got_last [8];
  int          got_cyc [8];
  int          first_vld_cyc;
  int          stall_err;
  int          rdy_err;
  bit          load_to;
  bit          get_to;
  logic        post_vld;
  logic        post_rdy;
  logic        post_busy;

  task automatic fill(input int base, input int which_b);
    for (int i = 0; i < 16; i++) ops[base+i] = a1[i];
    for (int i = 0; i < 8; i++)
      ops[base+16+i] = (which_b == 1) ? b1[i] : (which_b == 2) ? b2[i] : b3[i];
  endtask

  // Present n beats from ops[]; a beat completes in the cycle where in_valid and in_ready are both high.
  task automatic put_beats(input int n, input int gap_max);
    int t;
    int g;
    load_to = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (gap_max > 0) begin
        g = $urandom_range(0, gap_max);
        bus.in_valid = 1'b0;
        repeat (g) begin @(posedge clk); #1; end
      end
      bus.in_valid = 1'b1;
      bus.in_data  = ops[i];
      t = 0;
      while (!bus.in_ready && t < 200) begin @(posedge clk); #1; t++; end
      if (!bus.in_ready) begin
        load_to = 1'b1;
        break;
      end
      in_cyc[i] = cyc;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
  endtask

  // Accept n results; optionally alternate out_ready; track stalls and in_ready while busy.
  task automatic get_results(input int n, input bit toggle);
    int idx;
    int t;
    bit ph;
    bit held;
    logic [15:0] hd;
    logic hl;
    idx = 0; t = 0; ph = 1'b1; held = 1'b0; hd = '0; hl = 1'b0;
    stall_err = 0; rdy_err = 0; first_vld_cyc = -1;
    while (idx < n && t < 400) begin
      bus.out_ready = toggle ? ph : 1'b1;
      ph = ~ph;
      if (held) begin
        if (!bus.out_valid || bus.out_data !== hd || bus.out_last !== hl) stall_err++;
        held = 1'b0;
      end
      if (bus.busy && bus.in_ready) rdy_err++;
      if (bus.out_valid) begin
        if (first_vld_cyc < 0) first_vld_cyc = cyc;
        if (bus.out_ready) begin
          got[idx] = bus.out_data;
          got_last[idx] = bus.out_last;
          got_cyc[idx] = cyc;
          idx++;
        end else begin
          held = 1'b1;
          hd = bus.out_data;
          hl = bus.out_last;
        end
      end
      @(posedge clk); #1;
      t++;
    end
    bus.out_ready = 1'b0;
    get_to    = (idx < n);
    post_vld  = bus.out_valid;
    post_rdy  = bus.in_ready;
    post_busy = bus.busy;
  endtask

  task automatic test_reset;
    logic obs [5];
    logic expv [5];
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    obs  = '{bus.in_ready, bus.out_valid, (bus.out_data != 16'h0), bus.out_last, bus.busy};
    expv = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      vec_cnt++;
      if (obs[i] !== expv[i]) begin
        err_cnt++;
        $display("FAIL reset_out%0d: got %b expected %b", i, obs[i], expv[i]);
      end
    end
    rst = 1'b0;
    @(posedge clk); #1;
    vec_cnt++;
    if (bus.in_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL reset_release_in_ready: got %b expected 1", bus.in_ready);
    end
  endtask

  task automatic test_basic;
    fill(0, 1);
    put_beats(24, 0);
    vec_cnt++;
    if (load_to || bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
      err_cnt++;
      $display("FAIL basic_compute_entry: timeout %b busy %b in_ready %b expected 0 1 0", load_to, bus.busy, bus.in_ready);
    end
    get_results(8, 1'b0);
    vec_cnt++;
    if (get_to) begin err_cnt++; $display("FAIL basic_drain_timeout: got timeout expected 8 results"); end
    for (int k = 0; k < 8; k++) begin
      vec_cnt++;
      if (got[k] !== exp1[k]) begin
        err_cnt++;
        $display("FAIL basic_S%0d: got %h expected %h", k, got[k], exp1[k]);
      end
      vec_cnt++;
      if (got_last[k] !== (k == 7)) begin
        err_cnt++;
        $display("FAIL basic_last%0d: got %b expected %b", k, got_last[k], (k == 7));
      end
    end
    vec_cnt++;
    if (first_vld_cyc - in_cyc[23] !== 33) begin
      err_cnt++;
      $display("FAIL basic_latency: got %0d expected 33", first_vld_cyc - in_cyc[23]);
    end
    vec_cnt++;
    if (post_vld !== 1'b0 || post_rdy !== 1'b1 || post_busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL basic_after_S7: valid %b in_ready %b busy %b expected 0 1 0", post_vld, post_rdy, post_busy);
    end
    vec_cnt++;
    if (rdy_err !== 0) begin err_cnt++; $display("FAIL basic_in_ready_busy: got %0d expected 0", rdy_err); end
  endtask

  task automatic test_stall;
    fill(0, 2);
    put_beats(24, 0);
    get_results(8, 1'b1);
    vec_cnt++;
    if (load_to || get_to) begin err_cnt++; $display("FAIL stall_timeout: got %b%b expected 00", load_to, get_to); end
    for (int k = 0; k < 8; k++) begin
      vec_cnt++;
      if (got[k] !== exp2[k]) begin
        err_cnt++;
        $display("FAIL stall_S%0d: got %h expected %h", k, got[k], exp2[k]);
      end
    end
    vec_cnt++;
    if (stall_err !== 0) begin err_cnt++; $display("FAIL stall_hold: got %0d changes expected 0", stall_err); end
    vec_cnt++;
    if (rdy_err !== 0 || post_rdy !== 1'b1) begin
      err_cnt++;
      $display("FAIL stall_in_ready: busy-high count %0d post %b expected 0 1", rdy_err, post_rdy);
    end
  endtask

  task automatic test_gaps;
    fill(0, 3);
    put_beats(24, 3);
    get_results(8, 1'b0);
    vec_cnt++;
    if (load_to || get_to) begin err_cnt++; $display("FAIL gaps_timeout: got %b%b expected 00", load_to, get_to); end
    for (int k = 0; k < 8; k++) begin
      vec_cnt++;
      if (got[k] !== exp3[k]) begin
        err_cnt++;
        $display("FAIL gaps_S%0d: got %h expected %h", k, got[k], exp3[k]);
      end
    end
  endtask

  // A0=-1/256, A4=+1/256, B0=B1=0.5: products -128 and +128 (Q16.16); >>>8 gives -1 and 0.
  task automatic test_trunc;
    logic [15:0] e [8];
    e = '{16'hffff, 16'hffff, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    for (int i = 0; i < 24; i++) ops[i] = 16'h0000;
    ops[0] = 16'hffff; ops[4] = 16'h0001; ops[16] = 16'h0080; ops[17] = 16'h0080;
    put_beats(24, 0);
    get_results(8, 1'b0);
    for (int k = 0; k < 8; k++) begin
      vec_cnt++;
      if (got[k] !== e[k]) begin
        err_cnt++;
        $display("FAIL trunc_S%0d: got %h expected %h", k, got[k], e[k]);
      end
    end
  endtask

  // 7f00*7f00 = 3f010000, x4 = fc040000, >>>8 = fc0400 -> wraps to 0400.
  // 8000*7f00 = -3f800000, x4 = -fe000000, >>>8 = -fe0000 -> wraps to 0000.
  task automatic test_wrap_sat;
    logic [15:0] e_pos;
    logic [15:0] e_neg;
`ifdef MATMUL_SAT_EN
    e_pos = 16'h7fff; e_neg = 16'h8000;
`else
    e_pos = 16'h0400; e_neg = 16'h0000;
`endif
    for (int i = 0; i < 24; i++) ops[i] = 16'h7f00;
    put_beats(24, 0);
    get_results(8, 1'b0);
    for (int k = 0; k < 8; k++) begin
      vec_cnt++;
      if (got[k] !== e_pos) begin
        err_cnt++;
        $display("FAIL range_pos_S%0d: got %h expected %h", k, got[k], e_pos);
      end
    end
    for (int i = 0; i < 16; i++) ops[i] = 16'h8000;
    put_beats(24, 0);
    get_results(8, 1'b0);
    for (int k = 0; k < 8; k++) begin
      vec_cnt++;
      if (got[k] !== e_neg) begin
        err_cnt++;
        $display("FAIL range_neg_S%0d: got %h expected %h", k, got[k], e_neg);
      end
    end
  endtask

  task automatic test_reset_mid;
    fill(0, 1);
    put_beats(24, 0);
    repeat (10) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    vec_cnt++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin
      err_cnt++;
      $display("FAIL rst_compute: valid %b busy %b in_ready %b expected 0 0 0", bus.out_valid, bus.busy, bus.in_ready);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    vec_cnt++;
    if (bus.in_ready !== 1'b1) begin err_cnt++; $display("FAIL rst_compute_release: in_ready %b expected 1", bus.in_ready); end

    put_beats(24, 0);
    get_results(4, 1'b0);
    vec_cnt++;
    if (got[3] !== exp1[3]) begin err_cnt++; $display("FAIL rst_drain_S3: got %h expected %h", got[3], exp1[3]); end
    rst = 1'b1;
    @(posedge clk); #1;
    vec_cnt++;
    if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 || bus.out_data !== 16'h0 || bus.busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL rst_drain: valid %b last %b data %h busy %b expected 0 0 0000 0", bus.out_valid, bus.out_last, bus.out_data, bus.busy);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    vec_cnt++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL rst_drain_release: in_ready %b valid %b expected 1 0", bus.in_ready, bus.out_valid);
    end

    put_beats(24, 0);
    get_results(8, 1'b0);
    vec_cnt++;
    if (got[0] !== 16'hfd80 || got[7] !== 16'h2300 || get_to) begin
      err_cnt++;
      $display("FAIL rst_reload: S0 %h S7 %h timeout %b expected fd80 2300 0", got[0], got[7], get_to);
    end
  endtask

  task automatic test_back_to_back;
    fill(0, 1);
    fill(24, 2);
    fork
      put_beats(48, 0);
      get_results(8, 1'b0);
    join
    vec_cnt++;
    if (load_to || get_to) begin err_cnt++; $display("FAIL b2b_timeout: got %b%b expected 00", load_to, get_to); end
    vec_cnt++;
    if (in_cyc[24] !== got_cyc[7] + 1) begin
      err_cnt++;
      $display("FAIL b2b_restart: beat24 cycle %0d expected %0d", in_cyc[24], got_cyc[7] + 1);
    end
    vec_cnt++;
    if (rdy_err !== 0) begin err_cnt++; $display("FAIL b2b_no_accept_busy: got %0d expected 0", rdy_err); end
    vec_cnt++;
    if (got[0] !== exp1[0] || got[7] !== exp1[7] || got_last[7] !== 1'b1) begin
      err_cnt++;
      $display("FAIL b2b_first: S0 %h S7 %h last %b expected %h %h 1", got[0], got[7], got_last[7], exp1[0], exp1[7]);
    end
    get_results(8, 1'b0);
    for (int k = 0; k < 8; k++) begin
      vec_cnt++;
      if (got[k] !== exp2[k]) begin
        err_cnt++;
        $display("FAIL b2b_second_S%0d: got %h expected %h", k, got[k], exp2[k]);
      end
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = 16'h0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    test_reset;
    test_basic;
    test_stall;
    test_gaps;
    test_trunc;
    test_wrap_sat;
    test_reset_mid;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
